// File: rtl/fetch_stall_ctrl.sv
// Fetch-side hazard consumer: owns the PC and IF/ID register, and obeys stall,
// branch-flush and sticky halt requests. Also keeps a saturating stall-cycle counter.
module fetch_stall_ctrl #(
    parameter int              PC_W      = 16,
    parameter int              PC_INC    = 2,
    parameter logic [15:0]     NOP_INSTR = 16'h0000,
    parameter logic [PC_W-1:0] RST_PC    = '0,
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             br_taken,
    input  logic [PC_W-1:0]  br_target,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [15:0]      imem_data,
    output logic [15:0]      if_id_instr,
    output logic [PC_W-1:0]  if_id_pc_next,
    output logic             id_ex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [15:0]        instr_q, instr_d;
    logic [PC_W-1:0]    pc_next_q, pc_next_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0]    pc_inc;

    assign pc_inc = pc_q + PC_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            pc_q      <= RST_PC;
            instr_q   <= NOP_INSTR;
            pc_next_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            pc_next_q <= pc_next_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        pc_next_d = pc_next_q;
        cnt_d     = cnt_q;
        // Counter still advances on a flush or on the edge that samples halt_req.
        if (stall && state_q == RUN && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
        if (state_q == RUN) begin
            if (halt_req) begin
                state_d = HALT;
            end else if (br_taken) begin
                pc_d      = br_target;
                instr_d   = NOP_INSTR;
                pc_next_d = '0;
            end else if (!stall) begin
                pc_d      = pc_inc;
                instr_d   = imem_data;
                pc_next_d = pc_inc;
            end
        end
    end

    assign halted        = (state_q == HALT);
    assign imem_addr     = pc_q;
    assign if_id_instr   = instr_q;
    assign if_id_pc_next = pc_next_q;
    assign stall_cycles  = cnt_q;
    assign id_ex_bubble  = ~rst & (halted | br_taken | stall);

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed bench for fetch_stall_ctrl; CNT_W=2 so counter saturation is reachable.
module tb_fetch_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, halt_req = 1'b0, br_taken = 1'b0;
    logic [15:0] br_target = '0;
    logic [15:0] imem_addr, imem_data, if_id_instr, if_id_pc_next;
    logic        id_ex_bubble, halted;
    logic [1:0]  stall_cycles;
    int          checks = 0, errors = 0;

    // Instruction memory model: word at address a is a + 0x1000.
    assign imem_data = imem_addr + 16'h1000;

    always #5 clk = ~clk;

    fetch_stall_ctrl #(.PC_W(16), .PC_INC(2), .NOP_INSTR(16'h0000), .RST_PC(16'h0000), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .halt_req(halt_req), .br_taken(br_taken),
        .br_target(br_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .if_id_instr(if_id_instr), .if_id_pc_next(if_id_pc_next), .id_ex_bubble(id_ex_bubble),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [15:0] pc, input logic [15:0] ins,
                             input logic [15:0] pcn);
        chk({tag, "_pc"}, 32'(imem_addr), 32'(pc));
        chk({tag, "_instr"}, 32'(if_id_instr), 32'(ins));
        chk({tag, "_pcn"}, 32'(if_id_pc_next), 32'(pcn));
    endtask

    task automatic chk_reset(input string tag);
        chk_state(tag, 16'h0000, 16'h0000, 16'h0000);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_cnt"}, 32'(stall_cycles), 32'd0);
        chk({tag, "_bubble"}, 32'(id_ex_bubble), 32'd0);
    endtask

    initial begin
        // Reset: bubble must read 0 even with stall asserted.
        stall = 1'b1;
        #2;
        chk_reset("rst");
        tick();
        stall = 1'b0;
        rst   = 1'b0;
        #1;
        chk_state("t1_0", 16'h0000, 16'h0000, 16'h0000);

        // 1: normal fetch of A,B,C
        tick(); chk_state("t1_1", 16'h0002, 16'h1000, 16'h0002);
        tick(); chk_state("t1_2", 16'h0004, 16'h1002, 16'h0004);

        // 2: two-cycle stall holding B
        stall = 1'b1; #1;
        chk("t2_bub0", 32'(id_ex_bubble), 32'd1);
        tick(); chk_state("t2_1", 16'h0004, 16'h1002, 16'h0004);
        chk("t2_cnt1", 32'(stall_cycles), 32'd1);
        chk("t2_bub1", 32'(id_ex_bubble), 32'd1);
        tick(); chk_state("t2_2", 16'h0004, 16'h1002, 16'h0004);
        chk("t2_cnt2", 32'(stall_cycles), 32'd2);
        stall = 1'b0; #1;
        chk("t2_bub_off", 32'(id_ex_bubble), 32'd0);
        tick(); chk_state("t2_3", 16'h0006, 16'h1004, 16'h0006);

        // 3: flush with coincident stall
        stall = 1'b1; br_taken = 1'b1; br_target = 16'h0040; #1;
        chk("t3_bub", 32'(id_ex_bubble), 32'd1);
        tick(); chk_state("t3_1", 16'h0040, 16'h0000, 16'h0000);
        chk("t3_cnt", 32'(stall_cycles), 32'd3);
        stall = 1'b0; br_taken = 1'b0; #1;
        chk("t3_bub_off", 32'(id_ex_bubble), 32'd0);
        tick(); chk_state("t3_2", 16'h0042, 16'h1040, 16'h0042);

        // saturation at 2^CNT_W-1
        stall = 1'b1;
        tick(); chk("sat_cnt", 32'(stall_cycles), 32'd3);
        chk_state("sat", 16'h0042, 16'h1040, 16'h0042);

        // 4: halt pulse with coincident branch; halt wins
        stall = 1'b0; halt_req = 1'b1; br_taken = 1'b1; br_target = 16'h0080;
        tick(); chk("t4_halted", 32'(halted), 32'd1);
        chk_state("t4_1", 16'h0042, 16'h1040, 16'h0042);
        halt_req = 1'b0; br_taken = 1'b1; stall = 1'b1;
        tick(); chk_state("t4_2", 16'h0042, 16'h1040, 16'h0042);
        chk("t4_halted2", 32'(halted), 32'd1);
        br_taken = 1'b0; stall = 1'b0; #1;
        chk("t4_bub", 32'(id_ex_bubble), 32'd1);
        tick(); chk_state("t4_3", 16'h0042, 16'h1040, 16'h0042);
        chk("t4_bub2", 32'(id_ex_bubble), 32'd1);
        rst = 1'b1; #1;
        chk_reset("t4_rst");
        tick();
        rst = 1'b0;

        // 5: PC wrap and counter saturation after reset
        br_taken = 1'b1; br_target = 16'hFFFE;
        tick(); chk("t5_pc", 32'(imem_addr), 32'hFFFE);
        br_taken = 1'b0;
        tick(); chk_state("t5_wrap", 16'h0000, 16'h0FFE, 16'h0000);
        stall = 1'b1;
        tick(); tick();
        chk("t5_cnt2", 32'(stall_cycles), 32'd2);
        tick(); tick(); tick();
        chk("t5_cnt5", 32'(stall_cycles), 32'd3);
        chk_state("t5_hold", 16'h0000, 16'h0FFE, 16'h0000);

        // 6: async reset mid-stall, between edges
        #2;
        rst = 1'b1; #1;
        chk_reset("t6_rst");
        tick();
        rst = 1'b0; stall = 1'b0;
        tick(); chk_state("t6_run", 16'h0002, 16'h1000, 16'h0002);

        // 7: stalls while halted are not counted
        halt_req = 1'b1;
        tick(); chk("t7_halted", 32'(halted), 32'd1);
        halt_req = 1'b0; stall = 1'b1;
        tick(); tick();
        chk("t7_cnt", 32'(stall_cycles), 32'd0);
        chk_state("t7_hold", 16'h0002, 16'h1000, 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
